// File: rtl/cnn_pkg.sv
// Shared CNN front-end definitions: default image geometry, kernel size and
// the window-generator FSM state type.
package cnn_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_IMG_W  = 28;
  localparam int unsigned DEF_IMG_H  = 28;
  localparam int unsigned K          = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } wingen_state_t;

endpackage

// File: rtl/line_buffer_ram.sv
// One image row of pixel storage: asynchronous read, synchronous write on a
// single shared address. Reading during a write returns the old word, so the
// caller can forward the previous row's pixel in the same cycle.
// Ports:
//   clk       rising-edge clock
//   i_we      write enable
//   i_addr    column address (read and write)
//   i_wdata   write data
//   o_rdata_c combinational read data at i_addr
module line_buffer_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 28
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata_c
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port; no reset, contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator (no padding, stride 1). Buffers the
// two previous rows in line buffers and emits one window per valid position
// through a single valid/ready output register.
// Optional feature macro: WINGEN_COORD_EN adds win_row/win_col outputs.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     pixel handshake (in_ready is combinational)
//   in_pixel              raster-order pixel
//   win_valid/win_ready   window handshake
//   win_data              window, element (r,c) at [(r*3+c)*DATA_W +: DATA_W]
//   frame_done            one-cycle pulse after the last window is taken
//   win_row/win_col       window coordinates (WINGEN_COORD_EN only)
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_pixel,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic [K*K*DATA_W-1:0]   win_data,
  output logic                    frame_done
`ifdef WINGEN_COORD_EN
  ,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col
`endif
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  wingen_state_t          r_state;
  wingen_state_t          w_state_nxt;
  logic [COL_W-1:0]       r_col;
  logic [ROW_W-1:0]       r_row;
  logic                   r_win_valid;
  logic [K*K*DATA_W-1:0]  r_win_data;
  logic                   r_frame_done;
  logic                   w_frame_done_nxt;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_last_col;
  logic                   w_last_row;
  logic                   w_win_load;
  logic [DATA_W-1:0]      w_lb0_rd;
  logic [DATA_W-1:0]      w_lb1_rd;
  logic [DATA_W-1:0]      w_new_col [K];
  logic [DATA_W-1:0]      r_hist [K][2];
  logic [K*K*DATA_W-1:0]  w_win_next;

  assign w_in_ready = !reset && (r_state != DONE) && (!r_win_valid || win_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_last_col = (r_col == COL_W'(IMG_W - 1));
  assign w_last_row = (r_row == ROW_W'(IMG_H - 1));
  assign w_win_load = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

  // lb0 holds the previous row, lb1 the row before it.
  line_buffer_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk       (clk),
    .i_we      (w_accept),
    .i_addr    (r_col),
    .i_wdata   (in_pixel),
    .o_rdata_c (w_lb0_rd)
  );

  line_buffer_ram #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk       (clk),
    .i_we      (w_accept),
    .i_addr    (r_col),
    .i_wdata   (w_lb0_rd),
    .o_rdata_c (w_lb1_rd)
  );

  // Incoming right-hand column, top (oldest row) to bottom.
  always_comb begin
    w_new_col[0] = w_lb1_rd;
    w_new_col[1] = w_lb0_rd;
    w_new_col[2] = in_pixel;
  end

  // Two previous columns of the window; the third is the incoming column.
  // Stale columns after a row wrap or reset are shifted out by col 2.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < int'(K); r++) begin
        r_hist[r][0] <= r_hist[r][1];
        r_hist[r][1] <= w_new_col[r];
      end
    end
  end

  // Window as it will look after the current accept.
  always_comb begin
    w_win_next = '0;
    for (int r = 0; r < int'(K); r++) begin
      w_win_next[(r*3 + 0)*DATA_W +: DATA_W] = r_hist[r][0];
      w_win_next[(r*3 + 1)*DATA_W +: DATA_W] = r_hist[r][1];
      w_win_next[(r*3 + 2)*DATA_W +: DATA_W] = w_new_col[r];
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and frame_done request.
  always_comb begin
    w_state_nxt      = r_state;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = FILL;
      end
      FILL: begin
        if (w_accept && w_last_col && (r_row == ROW_W'(1))) w_state_nxt = STREAM;
      end
      STREAM: begin
        if (w_accept && w_last_col && w_last_row) w_state_nxt = DONE;
      end
      DONE: begin
        // Leave once the final window is gone or is being taken now.
        if (!r_win_valid || win_ready) begin
          w_state_nxt      = IDLE;
          w_frame_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output register: loads on a completing accept, holds under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_valid  <= 1'b0;
      r_win_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_done_nxt;
      if (w_win_load) begin
        r_win_valid <= 1'b1;
        r_win_data  <= w_win_next;
      end else if (win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

`ifdef WINGEN_COORD_EN
  logic [ROW_W-1:0] r_win_row;
  logic [COL_W-1:0] r_win_col;

  // Coordinates travel with win_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_row <= '0;
      r_win_col <= '0;
    end else if (w_win_load) begin
      r_win_row <= r_row - ROW_W'(2);
      r_win_col <= r_col - COL_W'(2);
    end
  end

  assign win_row = r_win_row;
  assign win_col = r_win_col;
`endif

  assign in_ready   = w_in_ready;
  assign win_valid  = r_win_valid;
  assign win_data   = r_win_data;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 5x4 instance driven by a hand-computed cycle
// table and directed sequences, and a 28x28 instance under random stalls
// checked against a reference window model.
module tb_conv_window_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 5;
  localparam int unsigned SH = 4;
  localparam int unsigned LW = 28;
  localparam int unsigned LH = 28;
  localparam int unsigned WB = 9 * DW;
  localparam int unsigned NTBL = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance
  logic          s_reset, s_in_valid, s_in_ready, s_win_valid, s_win_ready, s_frame_done;
  logic [DW-1:0] s_in_pixel;
  logic [WB-1:0] s_win_data;
  // large instance
  logic          l_reset, l_in_valid, l_in_ready, l_win_valid, l_win_ready, l_frame_done;
  logic [DW-1:0] l_in_pixel;
  logic [WB-1:0] l_win_data;
`ifdef WINGEN_COORD_EN
  logic [$clog2(SH)-1:0] s_win_row;
  logic [$clog2(SW)-1:0] s_win_col;
  logic [$clog2(LH)-1:0] l_win_row;
  logic [$clog2(LW)-1:0] l_win_col;
`endif

  conv_window_gen #(.DATA_W(DW), .IMG_W(SW), .IMG_H(SH)) dut_s (
    .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_pixel(s_in_pixel), .win_valid(s_win_valid), .win_ready(s_win_ready),
    .win_data(s_win_data), .frame_done(s_frame_done)
`ifdef WINGEN_COORD_EN
    , .win_row(s_win_row), .win_col(s_win_col)
`endif
  );

  conv_window_gen #(.DATA_W(DW), .IMG_W(LW), .IMG_H(LH)) dut_l (
    .clk(clk), .reset(l_reset), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_pixel(l_in_pixel), .win_valid(l_win_valid), .win_ready(l_win_ready),
    .win_data(l_win_data), .frame_done(l_frame_done)
`ifdef WINGEN_COORD_EN
    , .win_row(l_win_row), .win_col(l_win_col)
`endif
  );

  int n_pass;
  int n_total;

  // ---------------- monitors: record every window handshake ----------------
  logic [WB-1:0] s_got[$];
  logic [WB-1:0] l_got[$];
  int            l_rq[$];
  int            l_cq[$];
  int            s_fd_cnt = 0;
  int            l_fd_cnt = 0;

  always @(negedge clk) begin
    if (!s_reset && s_win_valid && s_win_ready) s_got.push_back(s_win_data);
    if (!s_reset && s_frame_done) s_fd_cnt++;
    if (!l_reset && l_win_valid && l_win_ready) begin
      l_got.push_back(l_win_data);
`ifdef WINGEN_COORD_EN
      l_rq.push_back(int'(l_win_row));
      l_cq.push_back(int'(l_win_col));
`endif
    end
    if (!l_reset && l_frame_done) l_fd_cnt++;
  end

  // Random window backpressure on the large instance.
  bit l_rand_rdy = 1'b0;
  initial begin
    l_win_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      l_win_ready = l_rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, want);
  endtask

  task automatic fail_now(input string nm);
    n_total++;
    $display("FAIL %s: timed out, got no event expected one", nm);
  endtask

  // Window whose top-left pixel value is tl in a frame of consecutive values.
  function automatic logic [WB-1:0] mkwin(input int tl, input int w);
    logic [WB-1:0] res;
    res = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        res[(r*3 + c)*DW +: DW] = DW'(tl + r*w + c);
    return res;
  endfunction

  // Present one pixel on the small instance until accepted; called at posedge+1.
  task automatic s_send(input logic [DW-1:0] p, output int stalls);
    logic acc;
    bit   done;
    stalls = 0;
    done = 1'b0;
    s_in_valid = 1'b1;
    s_in_pixel = p;
    while (!done) begin
      @(negedge clk);
      acc = s_in_ready;
      @(posedge clk); #1;
      if (acc) done = 1'b1;
      else begin
        stalls++;
        if (stalls > 50) begin
          fail_now($sformatf("s_send_px%0d", p));
          done = 1'b1;
        end
      end
    end
    s_in_valid = 1'b0;
  endtask

  task automatic s_wait_fd(input int target, input string nm);
    int n;
    n = 0;
    while (s_fd_cnt < target && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (s_fd_cnt < target) fail_now(nm);
  endtask

  // ---------------- cycle table for one clean 5x4 frame ----------------
  typedef struct {
    logic          vld;
    logic [DW-1:0] pix;
    logic          rdy;
    logic          e_in_ready;
    logic          e_win_valid;
    int            e_tl;
    logic          e_fd;
  } vec_t;

  vec_t tbl [NTBL];

  task automatic run_table(input string tag);
    int base;
    int fd0;
    base = s_got.size();
    fd0 = s_fd_cnt;
    for (int i = 0; i < int'(NTBL); i++) begin
      s_in_valid  = tbl[i].vld;
      s_in_pixel  = tbl[i].pix;
      s_win_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("%s_c%0d_in_ready", tag, i), WB'(s_in_ready), WB'(tbl[i].e_in_ready));
      chk($sformatf("%s_c%0d_win_valid", tag, i), WB'(s_win_valid), WB'(tbl[i].e_win_valid));
      chk($sformatf("%s_c%0d_frame_done", tag, i), WB'(s_frame_done), WB'(tbl[i].e_fd));
      if (tbl[i].e_win_valid)
        chk($sformatf("%s_c%0d_win_data", tag, i), s_win_data, mkwin(tbl[i].e_tl, SW));
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    chk({tag, "_win_count"}, WB'(s_got.size() - base), WB'(6));
    chk({tag, "_fd_count"}, WB'(s_fd_cnt - fd0), WB'(1));
  endtask

  // ---------------- main sequence ----------------
  logic [DW-1:0] lpix [LH][LW];

  initial begin
    int st;
    int base;
    int fd0;
    int exp_tl [6];
    int nexp;
    logic acc;
    int n;

    n_pass = 0;
    n_total = 0;
    s_reset = 1'b1; s_in_valid = 1'b0; s_in_pixel = '0; s_win_ready = 1'b0;
    l_reset = 1'b1; l_in_valid = 1'b0; l_in_pixel = '0;
    exp_tl = '{1, 2, 3, 6, 7, 8};

    // Hand-computed: pixel p completes a window when p in {13,14,15,18,19,20};
    // that window is visible the next cycle with top-left value p-12.
    for (int i = 0; i < 20; i++)
      tbl[i] = '{vld: 1'b1, pix: DW'(i + 1), rdy: 1'b1, e_in_ready: 1'b1,
                 e_win_valid: 1'b0, e_tl: 0, e_fd: 1'b0};
    tbl[13].e_win_valid = 1'b1; tbl[13].e_tl = 1;
    tbl[14].e_win_valid = 1'b1; tbl[14].e_tl = 2;
    tbl[15].e_win_valid = 1'b1; tbl[15].e_tl = 3;
    tbl[18].e_win_valid = 1'b1; tbl[18].e_tl = 6;
    tbl[19].e_win_valid = 1'b1; tbl[19].e_tl = 7;
    tbl[20] = '{vld: 1'b0, pix: '0, rdy: 1'b1, e_in_ready: 1'b0,
                e_win_valid: 1'b1, e_tl: 8, e_fd: 1'b0};          // DONE
    tbl[21] = '{vld: 1'b0, pix: '0, rdy: 1'b1, e_in_ready: 1'b1,
                e_win_valid: 1'b0, e_tl: 0, e_fd: 1'b1};          // frame_done
    tbl[22] = '{vld: 1'b0, pix: '0, rdy: 1'b1, e_in_ready: 1'b1,
                e_win_valid: 1'b0, e_tl: 0, e_fd: 1'b0};

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready_during", WB'(s_in_ready), WB'(0));
    chk("rst_l_in_ready_during", WB'(l_in_ready), WB'(0));
    @(posedge clk); #1;
    s_reset = 1'b0;
    l_reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_after", WB'(s_in_ready), WB'(1));
    chk("rst_win_valid", WB'(s_win_valid), WB'(0));
    chk("rst_win_data", s_win_data, WB'(0));
    chk("rst_frame_done", WB'(s_frame_done), WB'(0));
`ifdef WINGEN_COORD_EN
    chk("rst_win_row", WB'(s_win_row), WB'(0));
    chk("rst_win_col", WB'(s_win_col), WB'(0));
`endif
    @(posedge clk); #1;

    // Clean frame, full-rate.
    run_table("clean");

    // Back-to-back frames with in_valid held high throughout.
    s_win_ready = 1'b1;
    base = s_got.size();
    fd0 = s_fd_cnt;
    for (int p = 1; p <= 20; p++) s_send(DW'(p), st);
    s_send(DW'(101), st);
    chk("b2b_gap_stall", WB'(st >= 1), WB'(1));
    for (int p = 102; p <= 120; p++) s_send(DW'(p), st);
    s_wait_fd(fd0 + 2, "b2b_frame_done");
    chk("b2b_win_count", WB'(s_got.size() - base), WB'(12));
    nexp = (s_got.size() - base < 12) ? s_got.size() - base : 12;
    for (int k = 0; k < nexp; k++)
      chk($sformatf("b2b_win%0d", k), s_got[base + k],
          mkwin(exp_tl[k % 6] + ((k >= 6) ? 100 : 0), SW));

    // Backpressure on the first window for 5 cycles.
    base = s_got.size();
    fd0 = s_fd_cnt;
    s_win_ready = 1'b1;
    for (int p = 1; p <= 12; p++) s_send(DW'(p), st);
    s_win_ready = 1'b0;
    s_send(DW'(13), st);
    s_in_valid = 1'b1;
    s_in_pixel = DW'(14);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_c%0d_in_ready", i), WB'(s_in_ready), WB'(0));
      chk($sformatf("bp_c%0d_win_valid", i), WB'(s_win_valid), WB'(1));
      chk($sformatf("bp_c%0d_win_data", i), s_win_data, mkwin(1, SW));
      @(posedge clk); #1;
    end
    s_win_ready = 1'b1;
    for (int p = 14; p <= 20; p++) s_send(DW'(p), st);
    s_wait_fd(fd0 + 1, "bp_frame_done");
    chk("bp_win_count", WB'(s_got.size() - base), WB'(6));
    nexp = (s_got.size() - base < 6) ? s_got.size() - base : 6;
    for (int k = 0; k < nexp; k++)
      chk($sformatf("bp_win%0d", k), s_got[base + k], mkwin(exp_tl[k], SW));
    @(posedge clk); #1;

    // Reset after pixel 9, then a clean frame must match the table exactly.
    for (int p = 1; p <= 9; p++) s_send(DW'(p), st);
    s_reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", WB'(s_in_ready), WB'(0));
    @(posedge clk); #1;
    s_reset = 1'b0;
    @(negedge clk);
    chk("midrst_win_valid", WB'(s_win_valid), WB'(0));
    @(posedge clk); #1;
    run_table("after_rst");

    // Large frame with random input and output stalls vs reference model.
    for (int r = 0; r < int'(LH); r++)
      for (int c = 0; c < int'(LW); c++)
        lpix[r][c] = DW'($urandom);
    l_rand_rdy = 1'b1;
    for (int p = 0; p < int'(LW * LH); p++) begin
      while ($urandom_range(0, 3) == 0) begin
        l_in_valid = 1'b0;
        @(posedge clk); #1;
      end
      l_in_valid = 1'b1;
      l_in_pixel = lpix[p / LW][p % LW];
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
        @(negedge clk);
        acc = l_in_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) begin
        fail_now($sformatf("l_send_px%0d", p));
        p = LW * LH;
      end
    end
    l_in_valid = 1'b0;
    n = 0;
    while (l_fd_cnt < 1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (l_fd_cnt < 1) fail_now("l_frame_done");
    l_rand_rdy = 1'b0;
    chk("l_win_count", WB'(l_got.size()), WB'(676));
    nexp = (l_got.size() < 676) ? l_got.size() : 676;
    for (int k = 0; k < nexp; k++) begin
      logic [WB-1:0] w;
      int r0;
      int c0;
      r0 = k / int'(LW - 2);
      c0 = k % int'(LW - 2);
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[(r*3 + c)*DW +: DW] = lpix[r0 + r][c0 + c];
      chk($sformatf("l_win%0d", k), l_got[k], w);
`ifdef WINGEN_COORD_EN
      chk($sformatf("l_row%0d", k), WB'(l_rq[k]), WB'(r0));
      chk($sformatf("l_col%0d", k), WB'(l_cq[k]), WB'(c0));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
